// File: rtl/icebus_scheduler.sv
// Bus-ownership scheduler for the half-duplex motor bus: arbitrates frame requesters,
// waits for replies with a timeout window, then enforces a turnaround guard gap.
// Build option: define ICEBUS_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority).
module icebus_scheduler #(
  parameter int NUMBER_OF_REQUESTERS = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUMBER_OF_REQUESTERS-1:0] req,
  input  logic [NUMBER_OF_REQUESTERS-1:0] rsp_expected,
  input  logic [NUMBER_OF_REQUESTERS-1:0] frame_done,
  input  logic                            rx_frame_valid,
  input  logic [31:0]                     timeout_cycles,
  input  logic [15:0]                     guard_cycles,
  output logic [NUMBER_OF_REQUESTERS-1:0] grant,
  output logic [2:0]                      owner,
  output logic                            bus_busy,
  output logic                            timeout,
  output logic [15:0]                     timeout_count
);
  localparam int N = NUMBER_OF_REQUESTERS;

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_RESPONSE, GUARD} state_t;

  state_t         r_state;
  logic [N-1:0]   r_grant;
  logic [2:0]     r_owner;
  logic           r_busy;
  logic           r_timeout;
  logic [15:0]    r_timeout_count;
  logic [31:0]    r_cnt;
  logic           r_rsp;

  logic [2:0]     w_winner;
  logic [N-1:0]   w_onehot;
  logic           w_any;
  logic           w_rsp_sel;
  logic           w_own_done;
  logic           w_own_req;

`ifdef ICEBUS_ROUND_ROBIN_EN
  logic [2:0]     r_rr_ptr;
  logic [2:0]     w_win_hi;
  logic [2:0]     w_win_lo;
  logic           w_found_hi;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    w_win_hi   = '0;
    w_win_lo   = '0;
    w_found_hi = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) w_win_lo = 3'(i);
      if (req[i] && (i >= int'(r_rr_ptr))) begin
        w_win_hi   = 3'(i);
        w_found_hi = 1'b1;
      end
    end
    w_winner = w_found_hi ? w_win_hi : w_win_lo;
  end
`else
  always_comb begin
    w_winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) w_winner = 3'(i);
    end
  end
`endif

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < N; i++) w_onehot[i] = (w_winner == 3'(i));
  end

  assign w_any      = |req;
  assign w_rsp_sel  = |(rsp_expected & w_onehot);
  // r_grant is the owner's one-hot, so masking avoids indexing by owner.
  assign w_own_done = |(frame_done & r_grant);
  assign w_own_req  = |(req & r_grant);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_grant         <= '0;
      r_owner         <= '0;
      r_busy          <= 1'b0;
      r_timeout       <= 1'b0;
      r_timeout_count <= '0;
      r_cnt           <= '0;
      r_rsp           <= 1'b0;
`ifdef ICEBUS_ROUND_ROBIN_EN
      r_rr_ptr        <= '0;
`endif
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_onehot;
            r_owner <= w_winner;
            r_rsp   <= w_rsp_sel;
            r_busy  <= 1'b1;
            r_state <= GRANT;
`ifdef ICEBUS_ROUND_ROBIN_EN
            r_rr_ptr <= (w_winner == 3'(N - 1)) ? 3'd0 : w_winner + 3'd1;
`endif
          end
        end
        GRANT: begin
          if (w_own_done) begin
            r_grant <= '0;
            if (r_rsp) begin
              r_state <= WAIT_RESPONSE;
              r_cnt   <= timeout_cycles;
            end else begin
              r_state <= GUARD;
              r_cnt   <= {16'd0, guard_cycles};
            end
          end else if (!w_own_req) begin
            // Requester withdrew mid-frame: release the bus without a reply window.
            r_grant <= '0;
            r_state <= GUARD;
            r_cnt   <= {16'd0, guard_cycles};
          end
        end
        WAIT_RESPONSE: begin
          if (rx_frame_valid) begin
            r_state <= GUARD;
            r_cnt   <= {16'd0, guard_cycles};
          end else if (r_cnt == 32'd0) begin
            r_timeout <= 1'b1;
            if (r_timeout_count != 16'hFFFF) r_timeout_count <= r_timeout_count + 16'd1;
            r_state <= GUARD;
            r_cnt   <= {16'd0, guard_cycles};
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        GUARD: begin
          if (r_cnt == 32'd0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant         = r_grant;
  assign owner         = r_owner;
  assign bus_busy      = r_busy;
  assign timeout       = r_timeout;
  assign timeout_count = r_timeout_count;

endmodule

// File: tb/tb_icebus_scheduler.sv
// Directed bench for icebus_scheduler: a phase/window model predicts every output each
// cycle, and literal expectations pin grant latency, window length and arbitration order.
module tb_icebus_scheduler;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  rsp = '0;
  logic [N-1:0]  fd = '0;
  logic          rx = 1'b0;
  logic [31:0]   tcyc = 32'd100;
  logic [15:0]   gcyc = 16'd10;
  logic [N-1:0]  grant;
  logic [2:0]    owner;
  logic          bus_busy;
  logic          timeout;
  logic [15:0]   timeout_count;

  icebus_scheduler #(.NUMBER_OF_REQUESTERS(N)) dut (
    .clk(clk), .reset(reset), .req(req), .rsp_expected(rsp), .frame_done(fd),
    .rx_frame_valid(rx), .timeout_cycles(tcyc), .guard_cycles(gcyc),
    .grant(grant), .owner(owner), .bus_busy(bus_busy), .timeout(timeout),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 0;
  bit cmp_off = 0;
  bit preset_go = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 owning the bus, 2 reply window, 3 guard gap;
  // m_left is the number of cycles still remaining in the current window.
  int     m_phase = 0;
  longint m_left = 0;
  int     m_owner = 0;
  bit     m_rsp = 0;
  bit     m_to = 0;
  int     m_cnt = 0;
  int     m_next = 0;

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int i = 0; i < N; i++) begin
      if (r[(start + i) % N]) return (start + i) % N;
    end
    return 0;
  endfunction

  initial forever begin
    @(posedge clk);
    m_to = 0;
    if (!reset) begin
      m_phase = 0; m_owner = 0; m_cnt = 0; m_next = 0; m_left = 0; m_rsp = 0;
    end else begin
      if (preset_go) m_cnt = 16'hFFFD;
      case (m_phase)
        0: if (req != 0) begin
`ifdef ICEBUS_ROUND_ROBIN_EN
             m_owner = pick(req, m_next);
`else
             m_owner = pick(req, 0);
`endif
             m_rsp   = rsp[m_owner];
             m_next  = (m_owner + 1) % N;
             m_phase = 1;
           end
        1: if (fd[m_owner]) begin
             if (m_rsp) begin m_phase = 2; m_left = longint'(tcyc) + 1; end
             else begin m_phase = 3; m_left = longint'(gcyc) + 1; end
           end else if (!req[m_owner]) begin
             m_phase = 3; m_left = longint'(gcyc) + 1;
           end
        2: if (rx) begin
             m_phase = 3; m_left = longint'(gcyc) + 1;
           end else if (m_left == 1) begin
             m_to = 1;
             if (m_cnt < 65535) m_cnt++;
             m_phase = 3; m_left = longint'(gcyc) + 1;
           end else m_left--;
        default: if (m_left == 1) m_phase = 0; else m_left--;
      endcase
    end
    started = 1;
  end

  initial forever begin
    @(negedge clk);
    if (started && !cmp_off) begin
      check("grant", grant, (m_phase == 1) ? (longint'(1) << m_owner) : 0);
      check("owner", owner, m_owner);
      check("bus_busy", bus_busy, m_phase != 0);
      check("timeout", timeout, m_to);
      check("timeout_count", timeout_count, m_cnt);
      check("grant_onehot0", $countones(grant) <= 1, 1);
    end
  end

  task automatic wait_grant(input int budget);
    int k = 0;
    while (grant == 0 && k < budget) begin @(negedge clk); k++; end
    check("wait_grant", grant != 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (bus_busy && k < budget) begin @(negedge clk); k++; end
    check("wait_idle", bus_busy, 0);
  endtask

  // Single-frame transaction on channel 0 with an expected reply and no answer.
  task automatic ch0_timeout();
    req = 4'b0001; rsp = 4'b0001; tcyc = 0;
    wait_grant(30);
    fd = 4'b0001;
    @(negedge clk); fd = 0; req = 0;
    wait_idle(30);
  endtask

  int k;
  bit saw;
`ifdef ICEBUS_ROUND_ROBIN_EN
  int exp_ord[5] = '{0, 1, 2, 3, 0};
`else
  int exp_ord[5] = '{0, 0, 0, 0, 0};
`endif

  initial begin
    req = 4'b1111;
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", bus_busy, 0);
    check("rst_count", timeout_count, 0);

    // Fixed-priority pick, one cycle after req is first seen with reset high.
    reset = 1; req = 4'b0110;
    @(negedge clk);
    check("arb_grant", grant, 4'b0010);
    check("arb_owner", owner, 1);

    // Owner withdraws mid-frame; stray reply while granted is ignored.
    req = 4'b0100; rx = 1;
    @(negedge clk); rx = 0;
    check("abort_grant", grant, 0);
    check("abort_busy", bus_busy, 1);
    rsp = 4'b0100; tcyc = 100;
    wait_grant(40);
    check("ch2_grant", grant, 4'b0100);
    fd = 4'b0001;
    @(negedge clk); fd = 0; rsp = 0;
    check("nonowner_done", grant, 4'b0100);
    fd = 4'b0100;
    @(negedge clk); fd = 0; req = 0;
    k = 0;
    while (!timeout && k < 200) begin @(negedge clk); k++; end
    check("window_len", k, 101);
    check("count_1", timeout_count, 1);
    k = 0;
    while (bus_busy && k < 50) begin @(negedge clk); k++; end
    check("guard_len", k, 11);

    // Reply lands exactly on the expiry cycle.
    req = 4'b0001; rsp = 4'b0001; tcyc = 5; gcyc = 0;
    wait_grant(20);
    fd = 4'b0001;
    @(negedge clk); fd = 0; req = 0;
    repeat (5) @(negedge clk);
    rx = 1;
    @(negedge clk); rx = 0;
    saw = 0;
    repeat (10) begin if (timeout) saw = 1; @(negedge clk); end
    check("late_reply_no_to", saw, 0);
    check("late_reply_count", timeout_count, 1);

    // Zero-length window expires on its first cycle.
    req = 4'b0001; rsp = 4'b0001; tcyc = 0;
    wait_grant(20);
    fd = 4'b0001;
    @(negedge clk); fd = 0; req = 0;
    k = 0;
    while (!timeout && k < 20) begin @(negedge clk); k++; end
    check("zero_window", k, 1);
    check("count_2", timeout_count, 2);
    wait_idle(20);

    // Saturation: preset near the top, then three more timeouts.
    cmp_off = 1;
    @(negedge clk);
    force dut.r_timeout_count = 16'hFFFD;
    preset_go = 1;
    @(negedge clk);
    release dut.r_timeout_count;
    preset_go = 0;
    @(negedge clk);
    cmp_off = 0;
    ch0_timeout();
    check("count_fffe", timeout_count, 16'hFFFE);
    ch0_timeout();
    ch0_timeout();
    check("count_sat", timeout_count, 16'hFFFF);

    // Reset while channel 3 owns the bus.
    req = 4'b1000; rsp = 0;
    wait_grant(20);
    check("ch3_grant", grant, 4'b1000);
    reset = 0; req = 0;
    @(negedge clk);
    check("midrst_grant", grant, 0);
    check("midrst_busy", bus_busy, 0);
    check("midrst_count", timeout_count, 0);

    // Back-to-back zero-length transactions with everyone requesting.
    reset = 1; req = 4'b1111; rsp = 0; gcyc = 0;
    for (int i = 0; i < 5; i++) begin
      wait_grant(20);
      check("arb_order", owner, exp_ord[i]);
      fd = grant;
      @(negedge clk); fd = 0;
    end
    req = 0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
